controlador_irrigacao: RTL and testbench
========================================

// Module: controlador_irrigacao
// PURPOSE
//  Zone sequencer for the irrigation system. On start it walks zones 0..NUM_ZONES-1, opening one valve
//  at a time for that zone's 2-digit BCD duration (seconds), then inserts a settle gap before the next zone.
//  It contains its own 2-digit BCD down-counter, advanced by the shared 1 Hz tick, and drives the
//  seconds display digits. It sits between the configuration/sensor inputs and the valve drivers.
// PARAMETERS
//  NUM_ZONES    4  number of zones / valves (1..8)
//  GAP_SECONDS  2  settle time between zones, in ticks (0..15); 0 = no gap
// PORTS
//  clk           in   1             system clock
//  reset         in   1             asynchronous, active-low (0 = reset)
//  tick_1hz      in   1             one-clk-wide pulse, once per second
//  start         in   1             pulse; begins a cycle when idle
//  abort         in   1             pulse; cancels the cycle
//  pause         in   1             level; freezes the running zone
//  sensor_wet    in   1             soil wet; sampled at zone selection only
//  zone_enable   in   NUM_ZONES     per-zone enable
//  dur_uni       in   4*NUM_ZONES   per-zone units-of-seconds BCD digit; zone i = [4i+3:4i]
//  dur_dez       in   4*NUM_ZONES   per-zone tens-of-seconds BCD digit; same packing
//  valve         out  NUM_ZONES     one-hot valve drive (all 0 when not running)
//  busy          out  1             state != IDLE
//  done          out  1             one-clk pulse at normal end of cycle
//  cur_zone      out  3             zone index being processed
//  uni_segundos  out  4             remaining seconds, units digit
//  dez_segundos  out  4             remaining seconds, tens digit
//  error         out  1             sticky: a zone had a non-BCD digit (>9); cleared on accepted start
// BEHAVIOUR
//  Reset: state IDLE. valve=0, busy=0, done=0, cur_zone=0, digits=0, error=0. All outputs are registered.
//  IDLE:
//   - start -> SELECT with idx=0; clear error. start outside IDLE is ignored.
//  SELECT (one clk per zone examined):
//   - idx==NUM_ZONES -> DONE.
//   - Zone is skipped (idx+1, stay in SELECT) when:
//     - !zone_enable[idx], or
//     - duration==00, or
//     - sensor_wet==1, or
//     - either digit >9 (also sets error).
//   - Otherwise load the digits from dur_dez/dur_uni, go to RUN.
//  RUN:
//   - valve[idx]=1, starting the clk after the load.
//   - Each tick_1hz decrements BCD: units 0 -> 9 with tens-1.
//   - The tick that takes the count 01 -> 00 moves to GAP. valve clears on that same edge.
//   - Result: valve is open for exactly N ticks, where N = duration.
//  PAUSED:
//   - Entered from RUN when pause=1. valve=0, count held, ticks ignored.
//   - pause=0 -> RUN, valve reopens the next clk.
//  GAP:
//   - Internal 4-bit binary counter loaded with GAP_SECONDS, decremented per tick.
//   - At 0: idx+1 -> SELECT. With GAP_SECONDS=0, go straight from RUN to SELECT with idx+1.
//   - Digits read 00 during GAP.
//  DONE: done=1 for one clk -> IDLE; cur_zone returns to 0.
//  Priorities, highest first:
//   - abort: any non-IDLE state -> IDLE next edge. valve=0, digits=0, cur_zone=0, no done pulse, error kept.
//   - pause: in RUN, a simultaneous tick is not counted.
//   - tick.
//  Boundary rules:
//   - A tick arriving on the same clk as the SELECT load is not counted.
//   - pause in SELECT or GAP has no effect.
//   - Config inputs are sampled only in SELECT; changing them mid-zone does not alter the count.
//   - Reset mid-operation closes all valves asynchronously.
// TESTING
//  1. NUM_ZONES=4, GAP=2, all enabled, durations 03,00,12,01, start:
//     - valve0 high for 3 ticks; zone1 skipped.
//     - valve2 high for 12 ticks; digits 12,11,10,09..00.
//     - valve3 high for 1 tick; 2-tick gaps between zones; done pulse; busy=0.
//  2. Zone0 dur=20, pause for 5 ticks after 4 ticks:
//     - valve0 low while paused; digits hold 16.
//     - Resumes; total open ticks = 20.
//  3. Zone0 dur_uni=A (invalid):
//     - error=1; zone0 never opens; zone1 runs normally.
//     - Next start clears error.
//  4. abort during zone2 RUN, same clk as tick:
//     - Next clk: valve=0, busy=0, digits=00; no done pulse.
//     - start during the run was ignored.
//  5. sensor_wet=1 throughout, all zones enabled:
//     - SELECT skips all 4 zones in 4 clks; done 5 clks after start; no valve ever high.
//  6. Assert reset (0) mid-RUN: valve/busy/digits=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/controlador_irrigacao.sv
// Irrigation zone sequencer: walks the zones in order, opens one valve at a
// time for that zone's BCD duration, counts it down on the 1 Hz tick, and
// inserts a settle gap between zones.
module controlador_irrigacao #(
    parameter int unsigned NUM_ZONES   = 4,
    parameter int unsigned GAP_SECONDS = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tick_1hz,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   pause,
    input  logic                   sensor_wet,
    input  logic [NUM_ZONES-1:0]   zone_enable,
    input  logic [4*NUM_ZONES-1:0] dur_uni,
    input  logic [4*NUM_ZONES-1:0] dur_dez,
    output logic [NUM_ZONES-1:0]   valve,
    output logic                   busy,
    output logic                   done,
    output logic [2:0]             cur_zone,
    output logic [3:0]             uni_segundos,
    output logic [3:0]             dez_segundos,
    output logic                   error
);

    localparam int unsigned IDX_W = $clog2(NUM_ZONES + 1);
    localparam int unsigned GAP_W = 4;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ZONES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_RUN,
        S_PAUSED,
        S_GAP,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [3:0]           uni_q, uni_d;
    logic [3:0]           dez_q, dez_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [NUM_ZONES-1:0] valve_q, valve_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;

    logic [3:0]           sel_uni;
    logic [3:0]           sel_dez;
    logic                 sel_en;
    logic                 sel_bad;
    logic                 sel_skip;
    logic [IDX_W-1:0]     idx_inc;

    // Configuration of the zone currently addressed by idx
    always_comb begin
        sel_uni = '0;
        sel_dez = '0;
        sel_en  = 1'b0;
        for (int unsigned i = 0; i < NUM_ZONES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_uni = dur_uni[4*i +: 4];
                sel_dez = dur_dez[4*i +: 4];
                sel_en  = zone_enable[i];
            end
        end
        sel_bad  = (sel_uni > 4'd9) || (sel_dez > 4'd9);
        sel_skip = !sel_en || sel_bad || sensor_wet ||
                   ((sel_uni == 4'd0) && (sel_dez == 4'd0));
        idx_inc  = idx_q + IDX_W'(1);
    end

    // Next-state, countdown and registered-output logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        uni_d   = uni_q;
        dez_d   = dez_q;
        gap_d   = gap_q;
        done_d  = 1'b0;
        error_d = error_q;
        valve_d = '0;

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            idx_d   = '0;
            uni_d   = '0;
            dez_d   = '0;
            gap_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_SELECT;
                        idx_d   = '0;
                        error_d = 1'b0;
                    end
                end
                S_SELECT: begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        idx_d   = '0;
                    end else if (sel_skip) begin
                        idx_d = idx_inc;
                        if (sel_bad) error_d = 1'b1;
                    end else begin
                        uni_d   = sel_uni;
                        dez_d   = sel_dez;
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    // pause wins over a coincident tick
                    if (pause) begin
                        state_d = S_PAUSED;
                    end else if (tick_1hz) begin
                        if ((dez_q == 4'd0) && (uni_q == 4'd1)) begin
                            uni_d = 4'd0;
                            dez_d = 4'd0;
                            if (GAP_SECONDS == 0) begin
                                state_d = S_SELECT;
                                idx_d   = idx_inc;
                            end else begin
                                state_d = S_GAP;
                                gap_d   = GAP_W'(GAP_SECONDS);
                            end
                        end else if (uni_q == 4'd0) begin
                            uni_d = 4'd9;
                            dez_d = dez_q - 4'd1;
                        end else begin
                            uni_d = uni_q - 4'd1;
                        end
                    end
                end
                S_PAUSED: begin
                    if (!pause) state_d = S_RUN;
                end
                S_GAP: begin
                    if (gap_q == '0) begin
                        state_d = S_SELECT;
                        idx_d   = idx_inc;
                    end else if (tick_1hz) begin
                        gap_d = gap_q - GAP_W'(1);
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end
                default: begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
        if (state_d == S_RUN) begin
            for (int unsigned i = 0; i < NUM_ZONES; i++) begin
                if (idx_d == IDX_W'(i)) valve_d[i] = 1'b1;
            end
        end
    end

    // State and output registers; reset closes valves immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            uni_q   <= '0;
            dez_q   <= '0;
            gap_q   <= '0;
            valve_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            uni_q   <= uni_d;
            dez_q   <= dez_d;
            gap_q   <= gap_d;
            valve_q <= valve_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    assign valve        = valve_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign cur_zone     = 3'(idx_q);
    assign uni_segundos = uni_q;
    assign dez_segundos = dez_q;
    assign error        = error_q;

endmodule

// File: tb/tb_controlador_irrigacao.sv
// Testbench for the irrigation zone sequencer.
module tb_controlador_irrigacao;

    localparam int unsigned NZ  = 4;
    localparam int unsigned GAP = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              tick_1hz;
    logic              start;
    logic              abort;
    logic              pause;
    logic              sensor_wet;
    logic [NZ-1:0]     zone_enable;
    logic [4*NZ-1:0]   dur_uni;
    logic [4*NZ-1:0]   dur_dez;
    logic [NZ-1:0]     valve;
    logic              busy;
    logic              done;
    logic [2:0]        cur_zone;
    logic [3:0]        uni_segundos;
    logic [3:0]        dez_segundos;
    logic              error;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    controlador_irrigacao #(.NUM_ZONES(NZ), .GAP_SECONDS(GAP)) dut (
        .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .start(start),
        .abort(abort), .pause(pause), .sensor_wet(sensor_wet),
        .zone_enable(zone_enable), .dur_uni(dur_uni), .dur_dez(dur_dez),
        .valve(valve), .busy(busy), .done(done), .cur_zone(cur_zone),
        .uni_segundos(uni_segundos), .dez_segundos(dez_segundos), .error(error)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int zone_of(input logic [NZ-1:0] v);
        int z = -1;
        for (int i = NZ - 1; i >= 0; i--) if (v[i]) z = i;
        return z;
    endfunction

    task automatic test_reset();
        reset = 1'b0; tick_1hz = 0; start = 0; abort = 0; pause = 0; sensor_wet = 0;
        zone_enable = '0; dur_uni = '0; dur_dez = '0;
        step(); step();
        reset = 1'b1;
        step();
        checks++; if (valve !== '0) begin errors++; $display("FAIL reset_valve got %b expected 0", valve); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", done); end
        checks++; if (cur_zone !== 3'd0) begin errors++; $display("FAIL reset_cur_zone got %0d expected 0", cur_zone); end
        checks++; if (uni_segundos !== 4'd0 || dez_segundos !== 4'd0) begin
            errors++; $display("FAIL reset_digits got %0d%0d expected 00", dez_segundos, uni_segundos); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got %b expected 0", error); end
    endtask

    // Full cycle checked against a zone-level model: which zones open, in
    // what order, for how many ticks, remaining time, gaps, done, error.
    task automatic test_cycle(input string name, input logic [NZ-1:0] en,
                              input logic [4*NZ-1:0] u, input logic [4*NZ-1:0] d);
        int        exp_n[NZ];
        int        cnt[NZ];
        int        order[$];
        logic      exp_err = 1'b0;
        logic      prev_tick = 1'b0;
        logic [NZ-1:0] prev_valve = '0;
        logic      prev_busy = 1'b0;
        int        cur = -1;
        bit        had_close = 0;
        int        gap_ticks = 0;
        int        dones = 0;
        int        phase = 0;
        bit        fin = 0;
        int        z, rem, exp_z;
        for (int i = 0; i < NZ; i++) begin
            int uu, dd;
            bit bad;
            uu = int'(u[4*i +: 4]);
            dd = int'(d[4*i +: 4]);
            bad = (uu > 9) || (dd > 9);
            exp_n[i] = dd * 10 + uu;
            cnt[i] = 0;
            if (en[i] && bad) exp_err = 1'b1;
            if (en[i] && !bad && exp_n[i] != 0) order.push_back(i);
        end
        zone_enable = en; dur_uni = u; dur_dez = d;
        sensor_wet = 0; pause = 0; abort = 0; tick_1hz = 0;
        start = 1; step(); start = 0;
        for (int c = 0; c < 3000 && !fin; c++) begin
            if (prev_tick) begin
                if (prev_valve != '0) cnt[zone_of(prev_valve)]++;
                else if (prev_busy && had_close) gap_ticks++;
            end
            checks++; if (!$onehot0(valve)) begin errors++; $display("FAIL %s onehot got %b", name, valve); end
            if (valve != '0) begin
                z = zone_of(valve);
                if (z != cur) begin
                    exp_z = (order.size() > 0) ? order.pop_front() : -1;
                    checks++; if (z != exp_z) begin errors++; $display("FAIL %s zone_order got %0d expected %0d", name, z, exp_z); end
                    if (had_close) begin
                        checks++; if (gap_ticks != int'(GAP)) begin errors++; $display("FAIL %s gap_ticks got %0d expected %0d", name, gap_ticks, GAP); end
                    end
                    cur = z; gap_ticks = 0;
                end
                rem = exp_n[z] - cnt[z];
                checks++; if (dez_segundos !== 4'(rem / 10) || uni_segundos !== 4'(rem % 10)) begin
                    errors++; $display("FAIL %s digits got %0d%0d expected %0d", name, dez_segundos, uni_segundos, rem); end
                checks++; if (cur_zone !== 3'(z)) begin errors++; $display("FAIL %s cur_zone got %0d expected %0d", name, cur_zone, z); end
            end else begin
                checks++; if (uni_segundos !== 4'd0 || dez_segundos !== 4'd0) begin
                    errors++; $display("FAIL %s idle_digits got %0d%0d expected 00", name, dez_segundos, uni_segundos); end
                if (prev_valve != '0) begin
                    had_close = 1; gap_ticks = 0;
                    checks++; if (cnt[cur] != exp_n[cur]) begin errors++; $display("FAIL %s open_ticks zone %0d got %0d expected %0d", name, cur, cnt[cur], exp_n[cur]); end
                end
            end
            if (done) dones++;
            if (!busy) fin = 1;
            prev_valve = valve;
            prev_busy = busy;
            tick_1hz = (phase % 8 == 3);
            prev_tick = tick_1hz;
            phase++;
            if (!fin) step();
        end
        tick_1hz = 0;
        checks++; if (!fin) begin errors++; $display("FAIL %s timeout busy=%b expected 0", name, busy); end
        checks++; if (dones != 1) begin errors++; $display("FAIL %s done_pulses got %0d expected 1", name, dones); end
        checks++; if (order.size() != 0) begin errors++; $display("FAIL %s zones_not_opened got %0d expected 0", name, order.size()); end
        checks++; if (error !== exp_err) begin errors++; $display("FAIL %s error got %b expected %b", name, error, exp_err); end
        checks++; if (cur_zone !== 3'd0) begin errors++; $display("FAIL %s end_cur_zone got %0d expected 0", name, cur_zone); end
    endtask

    task automatic test_random(input int iters);
        for (int it = 0; it < iters; it++) begin
            logic [NZ-1:0]   en;
            logic [4*NZ-1:0] u, d;
            en = NZ'($urandom_range(0, 15));
            for (int i = 0; i < NZ; i++) begin
                u[4*i +: 4] = 4'($urandom_range(0, 9));
                d[4*i +: 4] = 4'($urandom_range(0, 2));
                if (en[i] && $urandom_range(0, 5) == 0) begin
                    if ($urandom_range(0, 1) == 1) u[4*i +: 4] = 4'($urandom_range(10, 15));
                    else d[4*i +: 4] = 4'($urandom_range(10, 15));
                end
            end
            test_cycle($sformatf("rand%0d", it), en, u, d);
        end
    endtask

    task automatic test_pause();
        int   cnt = 0, pticks = 0, phase = 0, dones = 0, rem;
        logic prev_tick = 0, prev_pause = 0;
        logic [NZ-1:0] prev_valve = '0;
        bit   released = 0, fin = 0, reopened = 0;
        zone_enable = 4'b0001; dur_uni = 16'h0000; dur_dez = 16'h0002;
        start = 1; step(); start = 0;
        for (int c = 0; c < 3000 && !fin; c++) begin
            if (prev_tick) begin
                if (prev_pause) pticks++;
                else if (prev_valve[0]) cnt++;
            end
            if (prev_pause) begin
                checks++; if (valve !== '0) begin errors++; $display("FAIL pause_valve got %b expected 0", valve); end
                checks++; if (dez_segundos !== 4'd1 || uni_segundos !== 4'd6) begin
                    errors++; $display("FAIL pause_digits got %0d%0d expected 16", dez_segundos, uni_segundos); end
            end else if (valve[0]) begin
                rem = 20 - cnt;
                if (released) reopened = 1;
                checks++; if (dez_segundos !== 4'(rem / 10) || uni_segundos !== 4'(rem % 10)) begin
                    errors++; $display("FAIL pause_run_digits got %0d%0d expected %0d", dez_segundos, uni_segundos, rem); end
            end else if (prev_valve[0]) begin
                checks++; if (cnt != 20) begin errors++; $display("FAIL pause_open_ticks got %0d expected 20", cnt); end
            end
            if (done) dones++;
            if (!busy) fin = 1;
            prev_valve = valve;
            if (!released && cnt >= 4 && pticks < 5) pause = 1;
            else if (pause && pticks >= 5) begin pause = 0; released = 1; end
            prev_pause = pause;
            tick_1hz = (phase % 8 == 3);
            prev_tick = tick_1hz;
            phase++;
            if (!fin) step();
        end
        tick_1hz = 0; pause = 0;
        checks++; if (!fin) begin errors++; $display("FAIL pause_timeout busy=%b expected 0", busy); end
        checks++; if (!reopened) begin errors++; $display("FAIL pause_reopen got 0 expected 1"); end
        checks++; if (dones != 1) begin errors++; $display("FAIL pause_done got %0d expected 1", dones); end
    endtask

    task automatic test_invalid();
        int c;
        test_cycle("invalid", 4'b0011, 16'h002A, 16'h0000);
        zone_enable = 4'b0001; dur_uni = 16'h0001; dur_dez = 16'h0000;
        start = 1; step(); start = 0;
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL error_clear got %b expected 0", error); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL error_restart_busy got %b expected 1", busy); end
        c = 0;
        while (busy && c < 500) begin tick_1hz = (c % 8 == 3); step(); c++; end
        tick_1hz = 0;
        checks++; if (busy) begin errors++; $display("FAIL error_restart_timeout busy=%b expected 0", busy); end
    endtask

    task automatic test_abort();
        int c = 0, phase = 0;
        bit dseen = 0;
        zone_enable = 4'b0111; dur_uni = 16'h0512; dur_dez = 16'h0000;
        start = 1; step(); start = 0;
        while (valve !== 4'b0001 && c < 200) begin tick_1hz = (phase % 8 == 3); phase++; step(); c++; end
        tick_1hz = 0;
        checks++; if (valve !== 4'b0001) begin errors++; $display("FAIL abort_zone0_open got %b expected 0001", valve); end
        start = 1; step(); start = 0;
        checks++; if (valve !== 4'b0001 || busy !== 1'b1 || cur_zone !== 3'd0) begin
            errors++; $display("FAIL start_ignored got valve=%b busy=%b zone=%0d expected 0001 1 0", valve, busy, cur_zone); end
        c = 0;
        while (valve !== 4'b0100 && c < 400) begin tick_1hz = (phase % 8 == 3); phase++; step(); c++; end
        tick_1hz = 0;
        checks++; if (valve !== 4'b0100) begin errors++; $display("FAIL abort_zone2_open got %b expected 0100", valve); end
        step(); step();
        abort = 1; tick_1hz = 1; step(); abort = 0; tick_1hz = 0;
        checks++; if (valve !== '0 || busy !== 1'b0) begin errors++; $display("FAIL abort_stop got valve=%b busy=%b expected 0 0", valve, busy); end
        checks++; if (uni_segundos !== 4'd0 || dez_segundos !== 4'd0 || cur_zone !== 3'd0) begin
            errors++; $display("FAIL abort_clear got digits=%0d%0d zone=%0d expected 00 0", dez_segundos, uni_segundos, cur_zone); end
        if (done) dseen = 1;
        for (int i = 0; i < 20; i++) begin tick_1hz = (i % 8 == 3); step(); if (done || busy) dseen = 1; end
        tick_1hz = 0;
        checks++; if (dseen) begin errors++; $display("FAIL abort_no_done got activity=1 expected 0"); end
    endtask

    task automatic test_wet();
        int k = 0;
        bit vseen;
        zone_enable = 4'b1111; dur_uni = 16'h1111; dur_dez = 16'h0000; sensor_wet = 1;
        start = 1; step(); start = 0;
        vseen = (valve != '0);
        while (!done && k < 20) begin step(); k++; if (valve != '0) vseen = 1; end
        checks++; if (k != 5) begin errors++; $display("FAIL wet_done_latency got %0d expected 5", k); end
        checks++; if (vseen) begin errors++; $display("FAIL wet_valve got open expected closed"); end
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wet_busy got %b expected 0", busy); end
        sensor_wet = 0;
    endtask

    task automatic test_async_reset();
        int c = 0;
        zone_enable = 4'b0001; dur_uni = 16'h0000; dur_dez = 16'h0001;
        start = 1; step(); start = 0;
        while (valve !== 4'b0001 && c < 20) begin step(); c++; end
        tick_1hz = 1; step(); tick_1hz = 0; step();
        checks++; if (valve !== 4'b0001 || dez_segundos !== 4'd0 || uni_segundos !== 4'd9) begin
            errors++; $display("FAIL areset_pre got valve=%b digits=%0d%0d expected 0001 09", valve, dez_segundos, uni_segundos); end
        reset = 1'b0;
        #2;
        checks++; if (valve !== '0 || busy !== 1'b0) begin errors++; $display("FAIL areset_async got valve=%b busy=%b expected 0 0", valve, busy); end
        checks++; if (uni_segundos !== 4'd0 || dez_segundos !== 4'd0) begin
            errors++; $display("FAIL areset_digits got %0d%0d expected 00", dez_segundos, uni_segundos); end
        #1;
        reset = 1'b1;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_idle got %b expected 0", busy); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_cycle("sequence", 4'b1111, {4'd1, 4'd2, 4'd0, 4'd3}, {4'd0, 4'd1, 4'd0, 4'd0});
        test_pause();
        test_invalid();
        test_abort();
        test_wet();
        test_random(5);
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
